// File: rtl/itcm_port_arbiter.sv
// Purpose: shares the single-port ITCM between instruction fetch and the load/store unit.
// Latency: grant is combinational, and read data returns exactly one cycle after the grant.
// Backpressure: the loser of arbitration holds its request; IF is forced through after STARVE_LIMIT MEM wins.
module itcm_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [1:0]        mem_width,
    input  logic              mem_sign_extend,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [31:0]       mem_rdata,
    output logic              mem_misaligned,
    output logic              itcm_en,
    output logic [3:0]        itcm_we,
    output logic [ADDR_W-1:0] itcm_addr,
    output logic [31:0]       itcm_wdata,
    input  logic [31:0]       itcm_rdata
);

    logic [3:0]  streak;
    logic        starved;
    logic        mem_mis;
    logic        ld_owner_mem;
    logic [1:0]  ld_off;
    logic [1:0]  ld_width;
    logic        ld_sign;
    logic        ld_mis;
    logic [31:0] if_rdata_q;
    logic [31:0] mem_rdata_q;
    logic [31:0] ld_shifted;
    logic [31:0] ld_ext;

    // Word-aligned fetches only need the word-address bits; upper bits wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, if_addr[31:ADDR_W+2], if_addr[1:0], mem_addr[31:ADDR_W+2]};

    assign starved = (streak == 4'(STARVE_LIMIT));
    assign mem_mis = (mem_width == 2'b01 && mem_addr[0]) ||
                     (mem_width[1] && mem_addr[1:0] != 2'b00);

    // Arbitration: MEM wins unless IF has waited STARVE_LIMIT grants.
    always_comb begin
        mem_gnt = 1'b0;
        if_gnt  = 1'b0;
        if (!rst) begin
            mem_gnt = mem_req && !(if_req && starved);
            if_gnt  = if_req && !mem_gnt;
        end
    end

    // RAM drive: address mux, byte enables and lane-replicated store data.
    always_comb begin
        itcm_addr  = mem_gnt ? mem_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
        itcm_en    = if_gnt || (mem_gnt && !mem_mis);
        itcm_we    = 4'b0000;
        itcm_wdata = mem_wdata;
        case (mem_width)
            2'b00:   itcm_wdata = {4{mem_wdata[7:0]}};
            2'b01:   itcm_wdata = {2{mem_wdata[15:0]}};
            default: itcm_wdata = mem_wdata;
        endcase
        if (mem_gnt && mem_we && !mem_mis) begin
            case (mem_width)
                2'b00:   itcm_we = 4'b0001 << mem_addr[1:0];
                2'b01:   itcm_we = mem_addr[1] ? 4'b1100 : 4'b0011;
                default: itcm_we = 4'b1111;
            endcase
        end
    end

    // Starvation streak: counts MEM wins while IF waits, saturating at the limit.
    always_ff @(posedge clk) begin
        if (rst || if_gnt || !if_req) begin
            streak <= 4'd0;
        end else if (mem_gnt && !starved) begin
            streak <= streak + 4'd1;
        end
    end

    // Response tracking: who owns next cycle's read data and how to format it.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rvalid      <= 1'b0;
            mem_rvalid     <= 1'b0;
            mem_misaligned <= 1'b0;
            ld_owner_mem   <= 1'b0;
            ld_off         <= 2'b00;
            ld_width       <= 2'b00;
            ld_sign        <= 1'b0;
            ld_mis         <= 1'b0;
        end else begin
            if_rvalid      <= if_gnt;
            mem_rvalid     <= mem_gnt && (mem_mis || !mem_we);
            mem_misaligned <= mem_gnt && mem_mis;
            ld_owner_mem   <= mem_gnt;
            if (mem_gnt) begin
                ld_off   <= mem_addr[1:0];
                ld_width <= mem_width;
                ld_sign  <= mem_sign_extend;
                ld_mis   <= mem_mis;
            end
        end
    end

    // Load alignment: select the addressed lane, then sign- or zero-extend.
    always_comb begin
        ld_shifted = itcm_rdata >> {ld_off, 3'b000};
        case (ld_width)
            2'b00:   ld_ext = ld_sign ? {{24{ld_shifted[7]}}, ld_shifted[7:0]}
                                      : {24'h0, ld_shifted[7:0]};
            2'b01:   ld_ext = ld_sign ? {{16{ld_shifted[15]}}, ld_shifted[15:0]}
                                      : {16'h0, ld_shifted[15:0]};
            default: ld_ext = itcm_rdata;
        endcase
        if (ld_mis) begin
            ld_ext = 32'h0;
        end
    end

    assign if_rdata  = if_rvalid ? itcm_rdata : if_rdata_q;
    assign mem_rdata = (mem_rvalid && ld_owner_mem) ? ld_ext : mem_rdata_q;

    // Hold registers keep the last delivered data visible while rvalid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata_q  <= 32'h0;
            mem_rdata_q <= 32'h0;
        end else begin
            if (if_rvalid) begin
                if_rdata_q <= itcm_rdata;
            end
            if (mem_rvalid) begin
                mem_rdata_q <= ld_ext;
            end
        end
    end

endmodule

// File: tb/tb_itcm_port_arbiter.sv
module tb_itcm_port_arbiter;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [1:0]        mem_width;
    logic              mem_sign_extend;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              mem_misaligned;
    logic              itcm_en;
    logic [3:0]        itcm_we;
    logic [ADDR_W-1:0] itcm_addr;
    logic [31:0]       itcm_wdata;
    logic [31:0]       itcm_rdata;

    logic [31:0] ram [0:(1<<ADDR_W)-1];

    int n_checks = 0;
    int n_pass   = 0;

    itcm_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_width(mem_width),
        .mem_sign_extend(mem_sign_extend), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_misaligned(mem_misaligned),
        .itcm_en(itcm_en), .itcm_we(itcm_we), .itcm_addr(itcm_addr),
        .itcm_wdata(itcm_wdata), .itcm_rdata(itcm_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered read and byte write enables.
    always @(posedge clk) begin
        if (itcm_en) begin
            for (int b = 0; b < 4; b++) begin
                if (itcm_we[b]) ram[itcm_addr][b*8 +: 8] <= itcm_wdata[b*8 +: 8];
            end
            itcm_rdata <= ram[itcm_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_drive(input logic req, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [1:0] width, input logic sx);
        mem_req = req; mem_we = we; mem_addr = addr;
        mem_wdata = wdata; mem_width = width; mem_sign_extend = sx;
    endtask

    // M=1, I=0 for each of ten contended cycles, oldest first.
    logic [9:0] starve_pat;

    initial begin
        for (int i = 0; i < (1<<ADDR_W); i++) ram[i] = 32'h0;
        ram[12'h080] = 32'h5A5A_0F0F;
        itcm_rdata = 32'h0;
        starve_pat = 10'b1111011110;

        // Reset with both ports requesting.
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h40;
        mem_drive(1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
        #1;
        check("rst_if_gnt",  {31'h0, if_gnt},  32'h0);
        check("rst_mem_gnt", {31'h0, mem_gnt}, 32'h0);
        check("rst_itcm_en", {31'h0, itcm_en}, 32'h0);
        check("rst_itcm_we", {28'h0, itcm_we}, 32'h0);
        tick();
        check("rst_if_rvalid",  {31'h0, if_rvalid},  32'h0);
        check("rst_mem_rvalid", {31'h0, mem_rvalid}, 32'h0);
        check("rst_mis",        {31'h0, mem_misaligned}, 32'h0);
        check("rst_if_rdata",   if_rdata,  32'h0);
        check("rst_mem_rdata",  mem_rdata, 32'h0);
        tick();
        rst = 1'b0;

        // Contention: MEM four times, then IF forced through, repeating.
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("starve_mem_gnt[%0d]", i), {31'h0, mem_gnt},  {31'h0, starve_pat[9-i]});
            check($sformatf("starve_if_gnt[%0d]", i),  {31'h0, if_gnt},   {31'h0, ~starve_pat[9-i]});
            tick();
        end
        if_req = 1'b0;
        mem_drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        tick();

        // Byte store into the top lane.
        mem_drive(1'b1, 1'b1, 32'h103, 32'h0000_00A5, 2'b00, 1'b0);
        #1;
        check("sb_gnt",   {31'h0, mem_gnt}, 32'h1);
        check("sb_we",    {28'h0, itcm_we}, 32'h8);
        check("sb_wdata", itcm_wdata, 32'hA5A5_A5A5);
        tick();
        check("sb_no_rvalid", {31'h0, mem_rvalid}, 32'h0);
        // Signed then unsigned byte load back, back-to-back.
        mem_drive(1'b1, 1'b0, 32'h103, 32'h0, 2'b00, 1'b1);
        tick();
        check("lb_s_rvalid", {31'h0, mem_rvalid}, 32'h1);
        check("lb_s_data",   mem_rdata, 32'hFFFF_FFA5);
        mem_drive(1'b1, 1'b0, 32'h103, 32'h0, 2'b00, 1'b0);
        tick();
        check("lbu_data", mem_rdata, 32'h0000_00A5);
        mem_drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        tick();
        check("hold_rvalid", {31'h0, mem_rvalid}, 32'h0);
        check("hold_data",   mem_rdata, 32'h0000_00A5);

        // Word store, then half loads from the upper half.
        mem_drive(1'b1, 1'b1, 32'h100, 32'h8001_1234, 2'b10, 1'b0);
        #1;
        check("sw_we",    {28'h0, itcm_we}, 32'hF);
        check("sw_wdata", itcm_wdata, 32'h8001_1234);
        tick();
        mem_drive(1'b1, 1'b0, 32'h102, 32'h0, 2'b01, 1'b1);
        tick();
        check("lh_s_data", mem_rdata, 32'hFFFF_8001);
        mem_drive(1'b1, 1'b0, 32'h102, 32'h0, 2'b01, 1'b0);
        tick();
        check("lhu_data", mem_rdata, 32'h0000_8001);
        // Half store into the upper half.
        mem_drive(1'b1, 1'b1, 32'h102, 32'h0000_BEEF, 2'b01, 1'b0);
        #1;
        check("sh_we",    {28'h0, itcm_we}, 32'hC);
        check("sh_wdata", itcm_wdata, 32'hBEEF_BEEF);
        tick();

        // Misaligned word load: slot used, no RAM access, error response.
        mem_drive(1'b1, 1'b0, 32'h101, 32'h0, 2'b10, 1'b0);
        #1;
        check("mis_gnt", {31'h0, mem_gnt}, 32'h1);
        check("mis_en",  {31'h0, itcm_en}, 32'h0);
        tick();
        check("mis_rvalid", {31'h0, mem_rvalid},     32'h1);
        check("mis_flag",   {31'h0, mem_misaligned}, 32'h1);
        check("mis_data",   mem_rdata, 32'h0);
        mem_drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);

        // Back-to-back IF then MEM; data must not cross.
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        check("b2b_if_gnt", {31'h0, if_gnt}, 32'h1);
        tick();
        if_req = 1'b0;
        mem_drive(1'b1, 1'b0, 32'h200, 32'h0, 2'b10, 1'b0);
        #1;
        check("b2b_if_rvalid",  {31'h0, if_rvalid},  32'h1);
        check("b2b_if_rdata",   if_rdata, 32'hBEEF_1234);
        check("b2b_mem_rvalid", {31'h0, mem_rvalid}, 32'h0);
        check("b2b_mem_gnt",    {31'h0, mem_gnt},    32'h1);
        tick();
        mem_drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        check("b2b_mem_rvalid2", {31'h0, mem_rvalid}, 32'h1);
        check("b2b_mem_rdata",   mem_rdata, 32'h5A5A_0F0F);
        check("b2b_if_rvalid2",  {31'h0, if_rvalid}, 32'h0);
        check("b2b_if_hold",     if_rdata, 32'hBEEF_1234);

        // Same pattern with reset landing in the second cycle.
        if_req = 1'b1; if_addr = 32'h200;
        tick();
        if_req = 1'b0;
        mem_drive(1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
        rst = 1'b1;
        #1;
        check("rstmid_if_rvalid", {31'h0, if_rvalid}, 32'h1);
        check("rstmid_mem_gnt",   {31'h0, mem_gnt},   32'h0);
        tick();
        check("rstmid_if_rvalid2",  {31'h0, if_rvalid},  32'h0);
        check("rstmid_mem_rvalid2", {31'h0, mem_rvalid}, 32'h0);
        rst = 1'b0;
        mem_drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
